// File: rtl/instr_retire_buffer_pkg.sv
// Shared types and constants for the in-order retirement buffer.
// The entry struct is sized for the default configuration below.
package instr_retire_buffer_pkg;

  localparam int INSTR_W = 32;
  localparam int REGNUM  = 32;
  localparam int BS      = 16;
  localparam int BS_BITS = $clog2(BS);
  localparam int RD_BITS = $clog2(REGNUM);
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               regwrite;
    logic               valid;
    logic               done;
  } entry_t;

endpackage

// File: rtl/instr_retire_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the retirement buffer.
// Flush and reset both collapse the buffer to empty with pointers at zero.
module retire_ptr_ctrl #(
  parameter int bs      = 16,
  parameter int bs_bits = $clog2(bs)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  output logic [bs_bits-1:0] head,
  output logic [bs_bits-1:0] tail,
  output logic [bs_bits:0]   occupancy,
  output logic               full
);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      // bs is a power of two, so pointer overflow is the wrap.
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)
        occupancy <= occupancy + (bs_bits+1)'(1);
      else if (pop && !push)
        occupancy <= occupancy - (bs_bits+1)'(1);
    end
  end

  assign full = (occupancy == (bs_bits+1)'(bs));

endmodule

// File: rtl/instr_retire_buffer.sv
// In-order retirement buffer: tags dispatches in program order, accepts
// out-of-order completions by tag, and releases entries strictly from the head.
module instr_retire_buffer
  import instr_retire_buffer_pkg::*;
#(
  parameter int Instr_word_size = INSTR_W,
  parameter int regnum          = REGNUM,
  parameter int bs              = BS,
  parameter int bs_bits         = $clog2(bs),
  parameter int rd_bits         = $clog2(regnum)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Instr_word_size-1:0] Instr_in,
  input  logic                       RegWrite_in,
  output logic [bs_bits-1:0]         alloc_tag,
  input  logic                       cmp_valid,
  input  logic [bs_bits-1:0]         cmp_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [Instr_word_size-1:0] Instr_out,
  output logic                       RegWrite_out,
  output logic [rd_bits-1:0]         rd_out,
  output logic [bs_bits:0]           occupancy,
  output logic                       cmp_err
);

  entry_t             ent [bs];
  logic [bs_bits-1:0] head;
  logic [bs_bits-1:0] tail;
  logic               full;
  logic               push;
  logic               pop;
  logic               cmp_ok;

  retire_ptr_ctrl #(.bs(bs), .bs_bits(bs_bits)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .head      (head),
    .tail      (tail),
    .occupancy (occupancy),
    .full      (full)
  );

  assign in_ready  = ~full;
  assign alloc_tag = tail;
  assign push      = in_valid & in_ready & ~flush;
  assign out_valid = ent[head].valid & ent[head].done & ~flush;
  assign pop       = out_valid & out_ready;
  assign cmp_ok    = ent[cmp_tag].valid & ~ent[cmp_tag].done;

  // Push, completion and pop never touch the same entry in one cycle:
  // tail==head only when empty or full, and a popped head is already done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < bs; i++) ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < bs; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      if (push) ent[tail] <= '{instr: Instr_in, regwrite: RegWrite_in, valid: 1'b1, done: 1'b0};
      if (cmp_valid && cmp_ok) ent[cmp_tag].done <= 1'b1;
      if (pop) begin
        ent[head].valid <= 1'b0;
        ent[head].done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      cmp_err <= 1'b0;
    else if (!flush && cmp_valid && !cmp_ok)
      cmp_err <= 1'b1;
  end

  assign Instr_out    = ent[head].instr;
  assign RegWrite_out = ent[head].regwrite;
  assign rd_out       = Instr_out[RD_LSB +: rd_bits];

endmodule
